// File: rtl/serial_pattern_detector_p.sv
// Serial pattern detector: matches the last PAT_W enabled bits against a programmable pattern.
// Optional saturating match counter enabled by defining PD_MATCH_COUNTER_EN.
module serial_pattern_detector_p #(
   parameter int PAT_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             enable,
   input  logic             serial_pattern,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             pattern_detected
`ifdef PD_MATCH_COUNTER_EN
   ,
   output logic [CNT_W-1:0] match_count,
   input  logic             count_clr
`endif
);

   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);

   if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_param_chk
      $error("serial_pattern_detector_p: PAT_W must be 2..32 and CNT_W >= 1");
   end

   typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;

   state_t           state, state_nxt;
   logic [PAT_W-1:0] shreg, shreg_nxt, shreg_shift;
   logic [FW-1:0]    fill, fill_nxt, fill_inc;
   logic             match;

   // newest bit enters at the MSB, so shreg[0] lines up with pattern[0] (oldest)
   assign shreg_shift = {serial_pattern, shreg[PAT_W-1:1]};
   assign fill_inc    = (fill == FULL) ? FULL : fill + 1'b1;

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         state            <= IDLE;
         shreg            <= '0;
         fill             <= '0;
         pattern_detected <= 1'b0;
      end else begin
         state            <= state_nxt;
         shreg            <= shreg_nxt;
         fill             <= fill_nxt;
         pattern_detected <= match;
      end
   end

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      fill_nxt  = fill;
      if (!enable) begin
         state_nxt = IDLE;
         fill_nxt  = '0;
      end else begin
         shreg_nxt = shreg_shift;
         if (match && !overlap) begin
            // non-overlapping: the matched window is discarded
            fill_nxt  = '0;
            state_nxt = FILL;
         end else begin
            fill_nxt  = fill_inc;
            state_nxt = (fill_inc == FULL) ? HUNT : FILL;
         end
      end
   end

   always_comb begin
      match = 1'b0;
      if (enable && (fill_inc == FULL) && (shreg_shift == pattern))
         match = 1'b1;
   end

`ifdef PD_MATCH_COUNTER_EN
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb)
         match_count <= '0;
      else if (count_clr)
         match_count <= match ? CNT_W'(1) : '0;
      else if (match && (match_count != '1))
         match_count <= match_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_serial_pattern_detector_p.sv
// Scoreboard bench: two detector instances (PAT_W=3 and PAT_W=8) checked cycle by cycle
// against a history-queue reference model; counter checks when PD_MATCH_COUNTER_EN is defined.
module tb_serial_pattern_detector_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstb;
   logic       en_a, d_a, ov_a, det_a;
   logic [2:0] pat_a;
   logic       en_b, d_b, ov_b, det_b;
   logic [7:0] pat_b;
`ifdef PD_MATCH_COUNTER_EN
   logic       clr_a, clr_b;
   logic [1:0] cnt_a;
   logic [7:0] cnt_b;
   int unsigned mcnt_a, mcnt_b;
   int unsigned expc_a[$], expc_b[$];
`endif

   serial_pattern_detector_p #(.PAT_W(3), .CNT_W(2)) dut_a (
      .clk(clk), .rstb(rstb), .enable(en_a), .serial_pattern(d_a),
      .pattern(pat_a), .overlap(ov_a), .pattern_detected(det_a)
`ifdef PD_MATCH_COUNTER_EN
      , .match_count(cnt_a), .count_clr(clr_a)
`endif
   );

   serial_pattern_detector_p #(.PAT_W(8), .CNT_W(8)) dut_b (
      .clk(clk), .rstb(rstb), .enable(en_b), .serial_pattern(d_b),
      .pattern(pat_b), .overlap(ov_b), .pattern_detected(det_b)
`ifdef PD_MATCH_COUNTER_EN
      , .match_count(cnt_b), .count_clr(clr_b)
`endif
   );

   bit hist_a[$], hist_b[$];
   bit exp_a[$], exp_b[$];
   int compared   = 0;
   int mismatched = 0;

   // true when the newest w bits of h, oldest first, equal p[0..w-1]
   function automatic bit window_match(input bit h[$], input int w, input logic [31:0] p);
      if (h.size() < w) return 1'b0;
      for (int i = 0; i < w; i++)
         if (h[h.size() - w + i] != p[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int unsigned cnt_next(input int unsigned c, input int unsigned mx,
                                            input bit m, input bit clr);
      if (clr) return m ? 1 : 0;
      if (m && c < mx) return c + 1;
      return c;
   endfunction

   task automatic tick();
      bit ma, mb;
      @(posedge clk);
      ma = 1'b0;
      mb = 1'b0;
      if (rstb) begin
         hist_a.delete();
         hist_b.delete();
      end else begin
         if (en_a) begin
            hist_a.push_back(d_a);
            if (hist_a.size() > 3) void'(hist_a.pop_front());
            ma = window_match(hist_a, 3, {29'b0, pat_a});
            if (ma && !ov_a) hist_a.delete();
         end else hist_a.delete();
         if (en_b) begin
            hist_b.push_back(d_b);
            if (hist_b.size() > 8) void'(hist_b.pop_front());
            mb = window_match(hist_b, 8, {24'b0, pat_b});
            if (mb && !ov_b) hist_b.delete();
         end else hist_b.delete();
      end
      exp_a.push_back(ma);
      exp_b.push_back(mb);
`ifdef PD_MATCH_COUNTER_EN
      if (rstb) begin
         mcnt_a = 0;
         mcnt_b = 0;
      end else begin
         mcnt_a = cnt_next(mcnt_a, 3, ma, clr_a);
         mcnt_b = cnt_next(mcnt_b, 255, mb, clr_b);
      end
      expc_a.push_back(mcnt_a);
      expc_b.push_back(mcnt_b);
`endif
      #2;
   endtask

   // asynchronous reset between edges: the expectation for the current cycle becomes 0
   task automatic rst_mid();
      rstb = 1'b1;
      if (exp_a.size() > 0) exp_a[exp_a.size() - 1] = 1'b0;
      if (exp_b.size() > 0) exp_b[exp_b.size() - 1] = 1'b0;
`ifdef PD_MATCH_COUNTER_EN
      if (expc_a.size() > 0) expc_a[expc_a.size() - 1] = 0;
      if (expc_b.size() > 0) expc_b[expc_b.size() - 1] = 0;
`endif
      tick();
      rstb = 1'b0;
   endtask

   task automatic bit_a(input bit b);
      en_a = 1'b1;
      d_a  = b;
      tick();
   endtask

   task automatic gap_a(input int n);
      en_a = 1'b0;
      repeat (n) tick();
   endtask

   always @(negedge clk) begin
      bit e;
      if (exp_a.size() > 0) begin
         e = exp_a.pop_front();
         compared++;
         if (det_a !== e) begin
            mismatched++;
            $display("FAIL det_a t=%0t got %b expected %b", $time, det_a, e);
         end
      end
      if (exp_b.size() > 0) begin
         e = exp_b.pop_front();
         compared++;
         if (det_b !== e) begin
            mismatched++;
            $display("FAIL det_b t=%0t got %b expected %b", $time, det_b, e);
         end
      end
`ifdef PD_MATCH_COUNTER_EN
      if (expc_a.size() > 0) begin
         int unsigned c;
         c = expc_a.pop_front();
         compared++;
         if (cnt_a !== 2'(c)) begin
            mismatched++;
            $display("FAIL cnt_a t=%0t got %0d expected %0d", $time, cnt_a, c);
         end
      end
      if (expc_b.size() > 0) begin
         int unsigned c;
         c = expc_b.pop_front();
         compared++;
         if (cnt_b !== 8'(c)) begin
            mismatched++;
            $display("FAIL cnt_b t=%0t got %0d expected %0d", $time, cnt_b, c);
         end
      end
`endif
   end

   initial begin
      rstb  = 1'b1;
      en_a  = 1'b0; d_a = 1'b0; ov_a = 1'b1; pat_a = 3'b101;
      en_b  = 1'b0; d_b = 1'b0; ov_b = 1'b1; pat_b = 8'hA5;
`ifdef PD_MATCH_COUNTER_EN
      clr_a = 1'b0; clr_b = 1'b0;
`endif
      tick();
      tick();
      rstb = 1'b0;
      gap_a(1);

      // overlapping: pulses after bit 3 and bit 5
      bit_a(1); bit_a(0); bit_a(1); bit_a(0); bit_a(1);
      gap_a(1);
      // non-overlapping: single pulse after bit 3
      ov_a = 1'b0;
      bit_a(1); bit_a(0); bit_a(1); bit_a(0); bit_a(1);
      gap_a(1);
      ov_a = 1'b1;
      // enable gap breaks the sequence
      bit_a(1); bit_a(0); gap_a(2); bit_a(1); bit_a(0); bit_a(1);
      gap_a(1);
      // reset after two valid bits; next match needs three fresh bits
      bit_a(1); bit_a(0);
      en_a = 1'b1; d_a = 1'b1;
      rst_mid();
      bit_a(1); bit_a(0); bit_a(1);
      gap_a(1);

`ifdef PD_MATCH_COUNTER_EN
      rst_mid();
      pat_a = 3'b111;
      repeat (8) bit_a(1);
      clr_a = 1'b1;
      bit_a(1);
      clr_a = 1'b0;
      bit_a(1);
      clr_a = 1'b1;
      gap_a(1);
      clr_a = 1'b0;
      gap_a(1);
      pat_a = 3'b101;
`endif

      // randomized phase on both instances, with an injected A5 on the 8-bit one
      for (int cyc = 0; cyc < 260; cyc++) begin
         if (cyc % 40 == 0) begin
            pat_a = 3'($urandom_range(0, 7));
            ov_a  = 1'($urandom_range(0, 1));
            ov_b  = 1'($urandom_range(0, 1));
         end
         en_a = ($urandom_range(0, 7) != 0);
         d_a  = 1'($urandom_range(0, 1));
         en_b = ($urandom_range(0, 15) != 0);
         d_b  = 1'($urandom_range(0, 1));
`ifdef PD_MATCH_COUNTER_EN
         clr_a = ($urandom_range(0, 31) == 0);
         clr_b = ($urandom_range(0, 63) == 0);
`endif
         if (cyc == 150) rst_mid();
         else if (cyc == 100) begin
            for (int i = 0; i < 8; i++) begin
               en_b = 1'b1;
               d_b  = pat_b[i];
               tick();
            end
         end else tick();
      end

      en_a = 1'b0;
      en_b = 1'b0;
`ifdef PD_MATCH_COUNTER_EN
      clr_a = 1'b0;
      clr_b = 1'b0;
`endif
      tick();
      tick();
      repeat (2) @(negedge clk);
      #1;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         mismatched++;
         $display("FAIL drain got %0d/%0d pending expected 0/0", exp_a.size(), exp_b.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
